// File: rtl/sha_padder.sv
`default_nettype none
// ============================================================================
// Module      : sha_padder
// Description : Streaming SHA-256 message padder. Packs 32-bit big-endian
//               message words into 512-bit blocks, appends the 0x80 marker,
//               zero fill and the 64-bit big-endian message bit length, and
//               hands the blocks out over a valid/ready handshake with a
//               final-block flag.
// Ports       : clk        - clock, all state updates on posedge
//               rst        - synchronous active-high reset
//               in_data    - message word, first byte in [31:24]
//               in_valid   - in_data/in_last/in_bytes valid
//               in_last    - final word of the message
//               in_bytes   - valid bytes in a last word (0..4, >4 means 4)
//               in_ready   - padder accepts a word this cycle
//               blk_data   - padded block, word x at [511-32*x -: 32]
//               blk_valid  - blk_data holds a complete block
//               blk_last   - block is the final block of the message
//               blk_ready  - consumer takes the block this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module sha_padder #(
  parameter int LEN_W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  in_data,
  input  logic         in_valid,
  input  logic         in_last,
  input  logic [2:0]   in_bytes,
  output logic         in_ready,
  output logic [511:0] blk_data,
  output logic         blk_valid,
  output logic         blk_last,
  input  logic         blk_ready
);

  localparam logic [31:0] C_MARKER = 32'h8000_0000;

  typedef enum logic [1:0] {
    S_FILL       = 2'd0,
    S_EMIT       = 2'd1,
    S_EMIT_MID   = 2'd2,
    S_EMIT_FINAL = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         w_q, w_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [511:0]       buf_q, buf_d;
  logic               mark_q, mark_d;

  logic               word_acc;
  logic [2:0]         nb;        // effective byte count of the incoming word
  logic [31:0]        word_m;    // incoming word with tail masked / marked
  logic [LEN_W-1:0]   len_acc;   // length including the incoming word
  logic [4:0]         pad_pos;   // word index that receives the 0x80 marker

  assign in_ready  = (state_q == S_FILL) && !rst;
  assign blk_valid = (state_q != S_FILL);
  assign blk_last  = (state_q == S_EMIT_FINAL);
  assign blk_data  = buf_q;
  assign word_acc  = in_valid && in_ready;

  always_comb begin
    nb = 3'd4;
    if (in_last && (in_bytes < 3'd4)) begin
      nb = in_bytes;
    end

    // Keep the first nb bytes; byte nb (if inside the word) carries the marker.
    word_m = '0;
    for (int b = 0; b < 4; b++) begin
      if (3'(b) < nb) begin
        word_m[31-8*b -: 8] = in_data[31-8*b -: 8];
      end else if (3'(b) == nb) begin
        word_m[31-8*b -: 8] = 8'h80;
      end
    end

    len_acc = len_q + LEN_W'({nb, 3'b000});
    // A fully-used last word pushes the marker into the following word.
    pad_pos = {1'b0, w_q} + ((nb == 3'd4) ? 5'd1 : 5'd0);
  end

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    len_d   = len_q;
    buf_d   = buf_q;
    mark_d  = mark_q;

    case (state_q)
      S_FILL: begin
        if (word_acc) begin
          buf_d[32*(15-int'(w_q)) +: 32] = word_m;
          w_d   = w_q + 4'd1;
          len_d = len_acc;
          if (!in_last) begin
            if (w_q == 4'd15) begin
              state_d = S_EMIT;
            end
          end else begin
            // Words after the marker are already zero: the buffer is cleared
            // whenever a new block starts.
            if ((nb == 3'd4) && (pad_pos <= 5'd15)) begin
              buf_d[32*(15-int'(pad_pos[3:0])) +: 32] = C_MARKER;
            end
            if (pad_pos <= 5'd13) begin
              buf_d[63:0] = 64'(len_acc);
              state_d     = S_EMIT_FINAL;
            end else begin
              // No room for the length field: it goes into an extra block.
              mark_d  = (pad_pos == 5'd16);
              state_d = S_EMIT_MID;
            end
          end
        end
      end

      S_EMIT: begin
        if (blk_ready) begin
          state_d = S_FILL;
          w_d     = '0;
          buf_d   = '0;
        end
      end

      S_EMIT_MID: begin
        if (blk_ready) begin
          buf_d           = '0;
          buf_d[511:480]  = mark_q ? C_MARKER : 32'h0;
          buf_d[63:0]     = 64'(len_q);
          state_d         = S_EMIT_FINAL;
        end
      end

      S_EMIT_FINAL: begin
        if (blk_ready) begin
          state_d = S_FILL;
          w_d     = '0;
          len_d   = '0;
          buf_d   = '0;
        end
      end

      default: begin
        state_d = S_FILL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FILL;
      w_q     <= '0;
      len_q   <= '0;
      buf_q   <= '0;
      mark_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      len_q   <= len_d;
      buf_q   <= buf_d;
      mark_q  <= mark_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sha_padder.sv
`default_nettype none
// ============================================================================
// Module      : tb_sha_padder
// Description : Self-checking bench for sha_padder. A byte-level padding
//               model predicts every block; a compare process checks each
//               valid output cycle against it. Literal blocks pin the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sha_padder;

  logic         clk;
  logic         rst;
  logic [31:0]  in_data;
  logic         in_valid;
  logic         in_last;
  logic [2:0]   in_bytes;
  logic         in_ready;
  logic [511:0] blk_data;
  logic         blk_valid;
  logic         blk_last;
  logic         blk_ready;

  typedef struct {
    logic [511:0] data;
    logic         last;
  } blk_t;

  blk_t        exp_q[$];
  logic [31:0] msg_w[$];
  int          checks = 0;
  int          errors = 0;

  sha_padder #(.LEN_W(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_bytes  (in_bytes),
    .in_ready  (in_ready),
    .blk_data  (blk_data),
    .blk_valid (blk_valid),
    .blk_last  (blk_last),
    .blk_ready (blk_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Compare process: every valid block cycle must match the model head.
  always @(negedge clk) begin
    if (!rst && (blk_valid !== 1'b0)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_block: got valid=%b last=%b want no block", blk_valid, blk_last);
      end else begin
        if (blk_valid !== 1'b1 || blk_data !== exp_q[0].data || blk_last !== exp_q[0].last) begin
          errors++;
          $display("FAIL block: got last=%b data=%h want last=%b data=%h",
                   blk_last, blk_data, exp_q[0].last, exp_q[0].data);
        end
        if (blk_ready) exp_q.pop_front();
      end
    end
  end

  // Model: standard SHA-256 padding of the byte string carried by msg_w.
  task automatic build_model(input int nb_last);
    logic [7:0]  bq[$];
    logic [63:0] bits;
    int          k;
    blk_t        b;
    for (int i = 0; i < msg_w.size(); i++) begin
      k = (i < msg_w.size() - 1) ? 4 : ((nb_last > 4) ? 4 : nb_last);
      for (int j = 0; j < k; j++) bq.push_back(msg_w[i][31-8*j -: 8]);
    end
    bits = 64'(bq.size()) * 64'd8;
    bq.push_back(8'h80);
    while ((bq.size() % 64) != 56) bq.push_back(8'h00);
    for (int j = 0; j < 8; j++) bq.push_back(bits[63-8*j -: 8]);
    for (int blk = 0; blk < bq.size() / 64; blk++) begin
      for (int j = 0; j < 64; j++) b.data[511-8*j -: 8] = bq[64*blk + j];
      b.last = (blk == bq.size() / 64 - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic push_word(input logic [31:0] d, input logic last, input logic [2:0] nb);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    in_bytes = nb;
    forever begin
      @(negedge clk);
      if (in_ready === 1'b1) break;
      n++;
      if (n > 100) begin
        checks++;
        errors++;
        $display("FAIL in_ready_timeout: got in_ready=%b want 1", in_ready);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic feed(input int nb_last);
    for (int i = 0; i < msg_w.size(); i++) begin
      if (i == msg_w.size() - 1) push_word(msg_w[i], 1'b1, 3'(nb_last));
      else                       push_word(msg_w[i], 1'b0, 3'd4);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d blocks pending want 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  logic [511:0] lit_abc, lit;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_bytes = 3'd0;
    in_data = '0; blk_ready = 1'b1;
    lit_abc = '0;
    lit_abc[511:480] = 32'h6162_6380;
    lit_abc[31:0]    = 32'h0000_0018;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("ready_in_reset", 512'(in_ready), 512'(1'b0));
    chk("valid_after_reset", 512'(blk_valid), 512'(1'b0));
    chk("last_after_reset", 512'(blk_last), 512'(1'b0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_idle", 512'(in_ready), 512'(1'b1));
    @(posedge clk); #1;

    // "abc"
    msg_w = '{32'h6162_6300};
    build_model(3);
    chk("model_abc_data", exp_q[0].data, lit_abc);
    chk("model_abc_last", 512'(exp_q[0].last), 512'(1'b1));
    feed(3);
    drain();

    // Empty message, one-cycle latency
    msg_w = '{32'hDEAD_BEEF};
    build_model(0);
    lit = '0; lit[511:480] = 32'h8000_0000;
    chk("model_empty", exp_q[0].data, lit);
    feed(0);
    @(negedge clk);
    chk("empty_latency_valid", 512'(blk_valid), 512'(1'b1));
    drain();

    // 14 full words then empty last word: marker in w14, length in extra block
    msg_w.delete();
    for (int i = 0; i < 15; i++) msg_w.push_back(32'h0101_0101);
    build_model(0);
    lit = '0;
    for (int i = 0; i < 14; i++) lit[511-32*i -: 32] = 32'h0101_0101;
    lit[63:32] = 32'h8000_0000;
    chk("model_14w_a", exp_q[0].data, lit);
    chk("model_14w_a_last", 512'(exp_q[0].last), 512'(1'b0));
    lit = '0; lit[31:0] = 32'h0000_01C0;
    chk("model_14w_b", exp_q[1].data, lit);
    feed(0);
    drain();

    // 16 full words: marker carried into the next block
    msg_w.delete();
    for (int i = 0; i < 16; i++) msg_w.push_back(32'h1111_1111 * 32'(i + 1));
    build_model(4);
    lit = '0; lit[511:480] = 32'h8000_0000; lit[31:0] = 32'h0000_0200;
    chk("model_16w_b", exp_q[1].data, lit);
    feed(4);
    drain();

    // in_bytes > 4 on a last word is treated as 4
    msg_w = '{32'h4142_4344};
    build_model(7);
    lit = '0; lit[511:480] = 32'h4142_4344; lit[479:448] = 32'h8000_0000; lit[31:0] = 32'h20;
    chk("model_clamp", exp_q[0].data, lit);
    feed(7);
    drain();

    // Marker in word 15 and in word 14 of a partial last word
    msg_w.delete();
    for (int i = 0; i < 16; i++) msg_w.push_back(32'hA5A5_0000 + 32'(i));
    build_model(2);
    feed(2);
    drain();
    msg_w.delete();
    for (int i = 0; i < 15; i++) msg_w.push_back(32'h5A00_0000 + 32'(i));
    build_model(1);
    feed(1);
    drain();

    // Backpressure on "abc"
    blk_ready = 1'b0;
    msg_w = '{32'h6162_6300};
    build_model(3);
    feed(3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 512'(blk_valid), 512'(1'b1));
      chk("bp_data", blk_data, lit_abc);
      chk("bp_ready_in", 512'(in_ready), 512'(1'b0));
    end
    @(posedge clk); #1;
    blk_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_after_valid", 512'(blk_valid), 512'(1'b0));
    chk("bp_after_ready_in", 512'(in_ready), 512'(1'b1));
    chk("bp_one_transfer", 512'(exp_q.size()), 512'(0));
    @(posedge clk); #1;

    // Reset after 7 words of a message: nothing may be emitted
    for (int i = 0; i < 7; i++) push_word(32'hC0C0_0000 + 32'(i), 1'b0, 3'd4);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_valid", 512'(blk_valid), 512'(1'b0));
    chk("rst_mid_ready_in", 512'(in_ready), 512'(1'b0));
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    msg_w = '{32'h6162_6300};
    build_model(3);
    feed(3);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got time limit want completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
